// File: rtl/alu_arbiter_if.sv
// Bundle between two ALU requesters, the arbiter and the shared ALU.
// slave: arbiter side; master: requesters and ALU side.
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req1_valid;
  logic             req0_ready;
  logic             req1_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [2:0]       req0_op;
  logic [2:0]       req1_op;
  logic             rsp0_valid;
  logic             rsp1_valid;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_sf;
  logic             rsp_zf;
  logic             rsp_err;
  logic [WIDTH-1:0] alu_srca;
  logic [WIDTH-1:0] alu_srcb;
  logic [2:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_result;
  logic             alu_sf;
  logic             alu_zf;

  modport slave (
    input  req0_valid, req1_valid,
    input  req0_a, req0_b, req1_a, req1_b,
    input  req0_op, req1_op,
    input  alu_result, alu_sf, alu_zf,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid,
    output rsp_result, rsp_sf, rsp_zf, rsp_err,
    output alu_srca, alu_srcb, alu_ctrl
  );

  modport master (
    output req0_valid, req1_valid,
    output req0_a, req0_b, req1_a, req1_b,
    output req0_op, req1_op,
    output alu_result, alu_sf, alu_zf,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid,
    input  rsp_result, rsp_sf, rsp_zf, rsp_err,
    input  alu_srca, alu_srcb, alu_ctrl
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters.
// Ports: clk, rst_n (async, active-low), bus (alu_arbiter_if.slave).
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          rst_n,
  alu_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  localparam logic [2:0] OP_UNDEF = 3'b011;

  state_t           state_q, state_d;
  logic             lg_q, lg_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] srca_q, srca_d;
  logic [WIDTH-1:0] srcb_q, srcb_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             sf_q, sf_d;
  logic             zf_q, zf_d;
  logic             err_q, err_d;
  logic             rv0_q, rv0_d;
  logic             rv1_q, rv1_d;

  logic gnt0;
  logic gnt1;
  logic idle;

  // Tie goes to the requester that did not win last.
  assign gnt0 = bus.req0_valid &
                (~bus.req1_valid | lg_q);
  assign gnt1 = bus.req1_valid &
                (~bus.req0_valid | ~lg_q);
  assign idle = (state_q == IDLE);

  assign bus.req0_ready = idle & gnt0;
  assign bus.req1_ready = idle & gnt1;

  always_comb begin
    state_d = state_q;
    lg_d    = lg_q;
    owner_d = owner_q;
    srca_d  = srca_q;
    srcb_d  = srcb_q;
    ctrl_d  = ctrl_q;
    res_d   = res_q;
    sf_d    = sf_q;
    zf_d    = zf_q;
    err_d   = err_q;
    rv0_d   = 1'b0;
    rv1_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          gnt1: begin
            srca_d  = bus.req1_a;
            srcb_d  = bus.req1_b;
            ctrl_d  = bus.req1_op;
            owner_d = 1'b1;
            lg_d    = 1'b1;
            state_d = EXEC;
          end
          gnt0: begin
            srca_d  = bus.req0_a;
            srcb_d  = bus.req0_b;
            ctrl_d  = bus.req0_op;
            owner_d = 1'b0;
            lg_d    = 1'b0;
            state_d = EXEC;
          end
          default: ;
        endcase
      end
      EXEC: begin
        res_d   = bus.alu_result;
        sf_d    = bus.alu_sf;
        zf_d    = bus.alu_zf;
        err_d   = (ctrl_q == OP_UNDEF);
        rv0_d   = ~owner_q;
        rv1_d   = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lg_q    <= 1'b1;
      owner_q <= 1'b0;
      srca_q  <= '0;
      srcb_q  <= '0;
      ctrl_q  <= '0;
      res_q   <= '0;
      sf_q    <= 1'b0;
      zf_q    <= 1'b0;
      err_q   <= 1'b0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lg_q    <= lg_d;
      owner_q <= owner_d;
      srca_q  <= srca_d;
      srcb_q  <= srcb_d;
      ctrl_q  <= ctrl_d;
      res_q   <= res_d;
      sf_q    <= sf_d;
      zf_q    <= zf_d;
      err_q   <= err_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
    end
  end

  assign bus.alu_srca   = srca_q;
  assign bus.alu_srcb   = srcb_q;
  assign bus.alu_ctrl   = ctrl_q;
  assign bus.rsp_result = res_q;
  assign bus.rsp_sf     = sf_q;
  assign bus.rsp_zf     = zf_q;
  assign bus.rsp_err    = err_q;
  assign bus.rsp0_valid = rv0_q;
  assign bus.rsp1_valid = rv1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus a random phase,
// with a behavioural shared ALU and per-requester scoreboards.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(32)) bus ();

  alu_arbiter #(.WIDTH(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  function automatic logic [33:0] alu_f(
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [31:0] r;
    case (op)
      3'b000:  r = a + b;
      3'b001:  r = a << b[4:0];
      3'b010:  r = a - b;
      3'b100:  r = a ^ b;
      3'b101:  r = a >> b[4:0];
      3'b110:  r = a | b;
      3'b111:  r = a & b;
      default: r = '0;
    endcase
    return {r[31], (r == 32'd0), r};
  endfunction

  function automatic logic [34:0] exp_f(
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    return {(op == 3'b011), alu_f(op, a, b)};
  endfunction

  // shared ALU
  logic [33:0] alu_r;
  assign alu_r = alu_f(bus.alu_ctrl, bus.alu_srca, bus.alu_srcb);
  assign bus.alu_result = alu_r[31:0];
  assign bus.alu_zf = alu_r[32];
  assign bus.alu_sf = alu_r[33];

  int n_tests = 0;
  int n_fail = 0;
  int n_acc0 = 0;
  int n_acc1 = 0;

  logic [34:0] q0[$];
  logic [34:0] q1[$];
  logic        gq[$];

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // monitor / scoreboard
  initial begin
    logic [34:0] e;
    logic        g;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("ready_onehot",
            64'(bus.req0_ready & bus.req1_ready), 64'd0);
        if (bus.rsp0_valid) begin
          if (q0.size() == 0) begin
            chk("rsp0_spurious", 64'(bus.rsp0_valid), 64'd0);
          end else begin
            e = q0.pop_front();
            chk("rsp0", 64'({bus.rsp_err, bus.rsp_sf,
                             bus.rsp_zf, bus.rsp_result}), 64'(e));
          end
        end
        if (bus.rsp1_valid) begin
          if (q1.size() == 0) begin
            chk("rsp1_spurious", 64'(bus.rsp1_valid), 64'd0);
          end else begin
            e = q1.pop_front();
            chk("rsp1", 64'({bus.rsp_err, bus.rsp_sf,
                             bus.rsp_zf, bus.rsp_result}), 64'(e));
          end
        end
        if (bus.req0_ready | bus.req1_ready) begin
          g = bus.req1_ready;
          if (gq.size() != 0) chk("grant", 64'(g), 64'(gq.pop_front()));
          if (bus.req0_ready && bus.req0_valid) begin
            q0.push_back(exp_f(bus.req0_op, bus.req0_a, bus.req0_b));
            n_acc0++;
          end
          if (bus.req1_ready && bus.req1_valid) begin
            q1.push_back(exp_f(bus.req1_op, bus.req1_a, bus.req1_b));
            n_acc1++;
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    gq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int b0, b1, np, lastc, k;
    bit seen;
    bit [1:0] expp;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_a = '0;
    bus.req0_b = '0;
    bus.req1_a = '0;
    bus.req1_b = '0;
    bus.req0_op = '0;
    bus.req1_op = '0;

    // reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_result", 64'(bus.rsp_result), 64'd0);
    chk("rst_rsp0v", 64'(bus.rsp0_valid), 64'd0);
    chk("rst_rsp1v", 64'(bus.rsp1_valid), 64'd0);
    chk("rst_srca", 64'(bus.alu_srca), 64'd0);
    chk("rst_ctrl", 64'(bus.alu_ctrl), 64'd0);
    chk("rst_flags", 64'({bus.rsp_sf, bus.rsp_zf, bus.rsp_err}), 64'd0);
    bus.req1_valid = 1'b1;
    #1;
    chk("rst_ready1", 64'(bus.req1_ready), 64'd1);
    chk("rst_ready0", 64'(bus.req0_ready), 64'd0);
    bus.req1_valid = 1'b0;

    // single op, first grant right after release
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_op = 3'b000;
    bus.req0_a = 32'd5;
    bus.req0_b = 32'd7;
    @(negedge clk);
    chk("s_ready0_c0", 64'(bus.req0_ready), 64'd1);
    chk("s_ready1_c0", 64'(bus.req1_ready), 64'd0);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    @(negedge clk);
    chk("s_ready0_exec", 64'(bus.req0_ready), 64'd0);
    chk("s_rsp0_c1", 64'(bus.rsp0_valid), 64'd0);
    chk("s_srca", 64'(bus.alu_srca), 64'd5);
    chk("s_srcb", 64'(bus.alu_srcb), 64'd7);
    @(negedge clk);
    chk("s_rsp0_c2", 64'(bus.rsp0_valid), 64'd1);
    chk("s_result", 64'(bus.rsp_result), 64'd12);
    chk("s_flags", 64'({bus.rsp_sf, bus.rsp_zf, bus.rsp_err}), 64'd0);
    @(negedge clk);
    chk("s_rsp0_c3", 64'(bus.rsp0_valid), 64'd0);
    chk("s_hold", 64'(bus.rsp_result), 64'd12);

    // tie then alternate
    do_reset();
    gq.push_back(1'b0);
    gq.push_back(1'b1);
    gq.push_back(1'b0);
    gq.push_back(1'b1);
    b0 = n_acc0 + n_acc1;
    np = 0;
    lastc = 0;
    bus.req0_op = 3'b010;
    bus.req0_a = 32'd3;
    bus.req0_b = 32'd3;
    bus.req1_op = 3'b010;
    bus.req1_a = 32'd3;
    bus.req1_b = 32'd4;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.rsp0_valid | bus.rsp1_valid) begin
        expp = (np % 2 == 0) ? 2'b01 : 2'b10;
        chk("tie_rsp_seq",
            64'({bus.rsp1_valid, bus.rsp0_valid}), 64'(expp));
        if (np > 0) chk("tie_spacing", 64'(c - lastc), 64'd2);
        if (bus.rsp0_valid) begin
          chk("tie_r0_res", 64'(bus.rsp_result), 64'd0);
          chk("tie_r0_zf", 64'(bus.rsp_zf), 64'd1);
        end
        if (bus.rsp1_valid) begin
          chk("tie_r1_res", 64'(bus.rsp_result), 64'hFFFF_FFFF);
          chk("tie_r1_sf", 64'(bus.rsp_sf), 64'd1);
        end
        lastc = c;
        np++;
      end
      @(posedge clk); #1;
      if (n_acc0 + n_acc1 >= b0 + 4) begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end
    end
    chk("tie_npulse", 64'(np), 64'd4);
    chk("tie_grants_left", 64'(gq.size()), 64'd0);

    // solo requester then tie
    gq.push_back(1'b1);
    gq.push_back(1'b1);
    gq.push_back(1'b1);
    gq.push_back(1'b0);
    b0 = n_acc0;
    b1 = n_acc1;
    for (int c = 0; c < 20; c++) begin
      k = n_acc1 - b1;
      if (n_acc0 > b0) begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end else begin
        bus.req1_valid = 1'b1;
        case (k)
          0: begin
            bus.req1_op = 3'b001;
            bus.req1_a = 32'd1;
            bus.req1_b = 32'd4;
          end
          1: begin
            bus.req1_op = 3'b100;
            bus.req1_a = 32'hF0;
            bus.req1_b = 32'hFF;
          end
          default: begin
            bus.req1_op = 3'b110;
            bus.req1_a = 32'h0F00;
            bus.req1_b = 32'h00F0;
          end
        endcase
        if (k >= 3) begin
          bus.req0_valid = 1'b1;
          bus.req0_op = 3'b111;
          bus.req0_a = 32'hFF00;
          bus.req0_b = 32'h0FF0;
        end
      end
      @(posedge clk); #1;
    end
    chk("solo_n1", 64'(n_acc1 - b1), 64'd3);
    chk("solo_n0", 64'(n_acc0 - b0), 64'd1);
    chk("solo_grants_left", 64'(gq.size()), 64'd0);

    // undefined op
    b0 = n_acc0;
    seen = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_op = 3'b011;
    bus.req0_a = 32'd9;
    bus.req0_b = 32'd9;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.rsp0_valid) begin
        chk("undef_err", 64'(bus.rsp_err), 64'd1);
        chk("undef_res", 64'(bus.rsp_result), 64'd0);
        chk("undef_zf", 64'(bus.rsp_zf), 64'd1);
        seen = 1'b1;
      end
      @(posedge clk); #1;
      if (n_acc0 > b0) bus.req0_valid = 1'b0;
    end
    chk("undef_seen", 64'(seen), 64'd1);

    // random traffic
    b0 = n_acc0;
    b1 = n_acc1;
    for (int c = 0; c < 200; c++) begin
      if (n_acc0 != b0) begin
        bus.req0_valid = 1'b0;
        b0 = n_acc0;
      end
      if (n_acc1 != b1) begin
        bus.req1_valid = 1'b0;
        b1 = n_acc1;
      end
      if (!bus.req0_valid && c < 180 && $urandom_range(0, 2) == 0) begin
        bus.req0_valid = 1'b1;
        bus.req0_op = 3'($urandom_range(0, 7));
        bus.req0_a = $urandom;
        bus.req0_b = $urandom;
      end
      if (!bus.req1_valid && c < 180 && $urandom_range(0, 2) == 0) begin
        bus.req1_valid = 1'b1;
        bus.req1_op = 3'($urandom_range(0, 7));
        bus.req1_a = $urandom;
        bus.req1_b = $urandom;
      end
      @(posedge clk); #1;
    end
    chk("rand_valid0_idle", 64'(bus.req0_valid), 64'd0);
    chk("rand_valid1_idle", 64'(bus.req1_valid), 64'd0);
    chk("rand_q0_drained", 64'(q0.size()), 64'd0);
    chk("rand_q1_drained", 64'(q1.size()), 64'd0);

    // reset during EXEC
    b1 = n_acc1;
    bus.req1_valid = 1'b1;
    bus.req1_op = 3'b101;
    bus.req1_a = 32'h8000_0000;
    bus.req1_b = 32'd4;
    for (int c = 0; c < 10 && n_acc1 == b1; c++) begin
      @(posedge clk); #1;
    end
    chk("mid_accepted", 64'(n_acc1 - b1), 64'd1);
    chk("mid_srca", 64'(bus.alu_srca), 64'h8000_0000);
    bus.req1_valid = 1'b0;
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    chk("mid_srca_rst", 64'(bus.alu_srca), 64'd0);
    chk("mid_srcb_rst", 64'(bus.alu_srcb), 64'd0);
    chk("mid_ctrl_rst", 64'(bus.alu_ctrl), 64'd0);
    chk("mid_res_rst", 64'(bus.rsp_result), 64'd0);
    chk("mid_flags_rst",
        64'({bus.rsp_sf, bus.rsp_zf, bus.rsp_err}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("mid_no_rsp1", 64'(bus.rsp1_valid), 64'd0);
    end
    @(posedge clk); #1;
    gq.push_back(1'b0);
    b0 = n_acc0;
    bus.req0_valid = 1'b1;
    bus.req0_op = 3'b000;
    bus.req0_a = 32'd1;
    bus.req0_b = 32'd1;
    bus.req1_valid = 1'b1;
    bus.req1_op = 3'b000;
    bus.req1_a = 32'd2;
    bus.req1_b = 32'd2;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (n_acc0 > b0) begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end
    end
    chk("mid_tie_n0", 64'(n_acc0 - b0), 64'd1);
    chk("mid_grants_left", 64'(gq.size()), 64'd0);
    chk("end_q0", 64'(q0.size()), 64'd0);
    chk("end_q1", 64'(q1.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width; the only supported value is 32, matching the ALU.
REQ-002 Port: clk  in  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 Ports: req0_valid / req1_valid  in  1  requester has an operation pending.
REQ-005 Ports: req0_ready / req1_ready  out  1  requester's operation is accepted this cycle.
REQ-006 Ports: req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands SrcA, SrcB.
REQ-007 Ports: req0_op / req1_op  in  3  ALUControl code: 000 add, 001 sll, 010 sub, 100 xor, 101 srl, 110 or, 111 and.
REQ-008 Ports: rsp0_valid / rsp1_valid  out  1  one-cycle pulse: result for that requester is on rsp_*.
REQ-009 Ports: rsp_result  out  WIDTH; rsp_sf, rsp_zf  out  1; rsp_err  out  1.
REQ-010 Ports: alu_srca, alu_srcb  out  WIDTH; alu_ctrl  out  3; these drive the shared ALU.
REQ-011 Ports: alu_result  in  WIDTH; alu_sf, alu_zf  in  1; these are returned by the shared ALU.

Function
REQ-012 FSM: two states, IDLE and EXEC; state is encoded in a single register.
REQ-013 IDLE, at least one valid: grant exactly one requester; assert its ready combinationally in the same cycle; the other ready stays 0.
REQ-014 Arbitration is round-robin via last-grant pointer lg:
  - on tie, grant requester !lg;
  - a single valid requester is granted regardless of lg;
  - lg updates to the granted index on acceptance.
REQ-015 Transfer occurs on the edge where valid&ready=1. On that edge:
  - operands and op are latched into alu_srca, alu_srcb, alu_ctrl;
  - the owner index is latched;
  - state moves to EXEC.
REQ-016 Both readys SHALL be 0 in EXEC; requesters SHALL hold valid, operands and op stable until ready is seen.
REQ-017 EXEC lasts exactly one cycle. On its closing edge:
  - alu_result, alu_sf, alu_zf are captured into rsp_result, rsp_sf, rsp_zf;
  - rsp<owner>_valid is set for exactly one cycle;
  - state returns to IDLE.
REQ-018 Latency: accept at edge N; response visible in cycle N+2 (after edge N+1). Throughput: one op per 2 cycles.
REQ-019 A new request may be accepted in the same IDLE cycle in which a response pulse is visible.
REQ-020 rsp_err = 1 with the response when the latched op is 3'b011 (undefined). The ALU output is still passed through unmodified (expected 0, zf=1).
REQ-021 rsp_result, rsp_sf, rsp_zf, rsp_err and alu_* hold their last values when not updated.
REQ-022 There is no response backpressure; a requester that is not listening loses the response.
REQ-023 No combinational path from alu_* inputs to any output.

Reset
REQ-024 When rst_n=0, immediately and independently of clk:
  - state = IDLE, lg = 1 (requester 0 wins the first tie);
  - all alu_*, rsp_* and rsp*_valid outputs = 0;
  - readys follow REQ-013 from IDLE.
REQ-025 Reset asserted during EXEC discards the in-flight operation; no rsp*_valid pulse follows reset release.
REQ-026 The first grant is possible in the first cycle after rst_n deasserts.

Verification
REQ-027 Single op: req0 add a=5, b=7 -> req0_ready in cycle 0; rsp0_valid in cycle 2; rsp_result=12, sf=0, zf=0, err=0.
REQ-028 Tie then alternate: both valid continuously after reset, op and operands per the directed list below -> grant order 0,1,0,1; rsp pulses alternate 0,1,0,1 at 2-cycle spacing.
  - req0: sub a=3, b=3;
  - req1: sub a=3, b=4;
  - expected rsp for req0: result 0, zf=1;
  - expected rsp for req1: result 0xFFFFFFFF, sf=1.
REQ-029 Solo requester fairness: only req1 valid for 3 ops, then both valid -> req1 granted 3 times, then req0 granted (lg=1).
REQ-030 Undefined op: req0 op=011, a=9, b=9 -> rsp0_valid with rsp_err=1, rsp_result=0, rsp_zf=1.
REQ-031 Reset mid-op: accept req1 srl a=0x80000000, b=4, then pull rst_n low during EXEC -> outputs 0 immediately; no rsp1_valid after release; next tie grants req0.
